// File: rtl/fifo_buf_to_uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and the
// serializer state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_e;

endpackage : uart_pkg

// File: rtl/fifo_buf_to_uart_if.sv
// FIFO reader handshake bundle. The master side issues the read trigger;
// the slave side is the FIFO reader that answers with rd_done/rd_data.
interface fifo_buf_to_uart_if;
    import uart_pkg::*;

    logic                      rd_rdy;
    logic                      rd_done;
    logic [UART_DATA_BITS-1:0] rd_data;
    logic                      is_empty;
    logic                      rd_trigger;

    modport master (
        input  rd_rdy,
        input  rd_done,
        input  rd_data,
        input  is_empty,
        output rd_trigger
    );

    modport slave (
        output rd_rdy,
        output rd_done,
        output rd_data,
        output is_empty,
        input  rd_trigger
    );

endinterface : fifo_buf_to_uart_if

// File: rtl/fifo_buf_to_uart_tx_serializer.sv
// UART 8N1 serializer: one start bit, eight data bits LSB first, one stop bit,
// each held CLKS_PER_BIT cycles. tx is registered from the current state.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tx_start,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      tx,
    output logic                      done
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             bit_tc;

    assign bit_tc = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        tx_d      = 1'b1;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (tx_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_tc) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = data[bit_idx_q];
                if (bit_tc) begin
                    cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_tc) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx   = tx_q;
    assign done = done_q;

endmodule : uart_tx_serializer

// File: rtl/fifo_buf_to_uart.sv
// Drains the outbound FIFO one byte at a time: one read handshake, then one
// UART frame, strictly in sequence.
module fifo_buf_to_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic               clk,
    input  logic               reset,
    fifo_buf_to_uart_if.master rd,
    output logic               tx,
    output logic               busy,
    output logic               tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_TRIGGER,
        RD_WAIT_DONE,
        TX_START,
        TX_WAIT_DONE
    } rd_state_e;

    rd_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      trigger;
    logic                      tx_start;
    logic                      ser_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
        end
    end

    // The byte register only loads in RD_WAIT_DONE, so it holds for the whole frame.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        trigger  = 1'b0;
        tx_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rd.rd_rdy && !rd.is_empty) begin
                    state_d = RD_TRIGGER;
                end
            end
            RD_TRIGGER: begin
                trigger = 1'b1;
                if (!rd.rd_rdy) begin
                    state_d = RD_WAIT_DONE;
                end
            end
            RD_WAIT_DONE: begin
                if (rd.rd_done) begin
                    byte_d  = rd.rd_data;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                tx_start = 1'b1;
                state_d  = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (ser_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .data    (byte_q),
        .tx      (tx),
        .done    (ser_done)
    );

    assign rd.rd_trigger = trigger;
    assign busy          = (state_q != IDLE);
    assign tx_done       = ser_done;

endmodule : fifo_buf_to_uart

// File: tb/tb_fifo_buf_to_uart.sv
// Directed bench for fifo_buf_to_uart at 4 clocks per bit, with a FIFO reader
// model and a frame scoreboard decoding tx.
module tb_fifo_buf_to_uart;

    localparam int CPB = 4;

    logic clk;
    logic reset;
    logic tx;
    logic busy;
    logic tx_done;

    fifo_buf_to_uart_if rd();

    fifo_buf_to_uart #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .tx     (tx),
        .busy   (busy),
        .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int unsigned reads    = 0;
    int unsigned rd_phase = 0;
    logic        hold_rdy_low = 1'b0;
    logic        spur_req     = 1'b0;

    int unsigned trig_cnt  = 0;
    int unsigned done_cnt  = 0;
    logic        trig_prev = 1'b0;
    logic        mon_active = 1'b0;
    logic        mon_post   = 1'b0;
    int unsigned mon_n      = 0;
    logic [39:0] pat;
    logic [39:0] dpat;
    logic        bz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame_pat(input logic [7:0] b);
        logic [39:0] p;
        logic        v;
        p = '0;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      v = 1'b0;
            else if (s == 9) v = 1'b1;
            else             v = b[s-1];
            for (int j = 0; j < CPB; j++) p[s*CPB + j] = v;
        end
        return p;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic expect_frame);
        fifo_q.push_back(b);
        if (expect_frame) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || mon_active || mon_post ||
                busy || rd_phase != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 2000), 64'd1);
    endtask

    // FIFO reader model: drops rd_rdy the cycle after it sees the trigger,
    // pulses rd_done two cycles later with the popped byte.
    initial begin
        rd.rd_rdy   = 1'b1;
        rd.rd_done  = 1'b0;
        rd.rd_data  = '0;
        rd.is_empty = 1'b1;
        forever begin
            @(negedge clk);
            rd.rd_done = 1'b0;
            case (rd_phase)
                0: begin
                    if (rd.rd_trigger) begin
                        rd.rd_rdy = 1'b0;
                        rd_phase  = 1;
                    end else begin
                        rd.rd_rdy = !hold_rdy_low;
                        if (spur_req) begin
                            rd.rd_data = 8'hEE;
                            rd.rd_done = 1'b1;
                            spur_req   = 1'b0;
                        end
                    end
                end
                1: rd_phase = 2;
                default: begin
                    if (fifo_q.size() > 0) rd.rd_data = fifo_q.pop_front();
                    rd.rd_done = 1'b1;
                    reads++;
                    rd_phase  = 0;
                    rd.rd_rdy = !hold_rdy_low;
                end
            endcase
            rd.is_empty = (fifo_q.size() == 0);
        end
    end

    // Frame monitor: captures 40 samples from the first start-bit cycle and
    // compares line, tx_done position and busy against the scoreboard.
    initial begin
        logic [7:0]  e;
        logic [39:0] done_exp;
        done_exp = 40'd1;
        done_exp = done_exp << 39;
        forever begin
            @(negedge clk);
            if (rd.rd_trigger && !trig_prev) trig_cnt++;
            trig_prev = rd.rd_trigger;
            if (tx_done === 1'b1) done_cnt++;
            if (reset) begin
                mon_active = 1'b0;
                mon_post   = 1'b0;
                mon_n      = 0;
            end else begin
                if (mon_post) begin
                    check("busy_after_tx_done", 64'(busy), 64'd0);
                    mon_post = 1'b0;
                end
                if (!mon_active && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_n      = 0;
                    pat        = '0;
                    dpat       = '0;
                    bz         = 1'b1;
                end
                if (mon_active) begin
                    pat[mon_n]  = tx;
                    dpat[mon_n] = tx_done;
                    bz          = bz & busy;
                    mon_n++;
                    if (mon_n == 40) begin
                        mon_active = 1'b0;
                        mon_post   = 1'b1;
                        check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("frame_bits", 64'(pat), 64'(frame_pat(e)));
                            check("tx_done_position", 64'(dpat), 64'(done_exp));
                            check("busy_during_frame", 64'(bz), 64'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int unsigned snap;
        int unsigned dsnap;
        int unsigned rsnap;
        int unsigned n;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_rd_trigger", 64'(rd.rd_trigger), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_tx_done", 64'(tx_done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        repeat (20) @(negedge clk);
        check("empty_no_trigger", 64'(trig_cnt), 64'd0);
        check("empty_not_busy", 64'(busy), 64'd0);

        push_byte(8'hA5, 1'b1);
        wait_drain("drain_single");
        check("single_reads", 64'(reads), 64'd1);
        check("single_tx_done_count", 64'(done_cnt), 64'd1);

        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        wait_drain("drain_back_to_back");
        check("b2b_reads", 64'(reads), 64'd3);
        check("b2b_tx_done_count", 64'(done_cnt), 64'd3);

        @(posedge clk);
        #1 hold_rdy_low = 1'b1;
        repeat (2) @(negedge clk);
        snap = trig_cnt;
        push_byte(8'h5A, 1'b1);
        repeat (30) @(negedge clk);
        check("rdy_low_no_trigger", 64'(trig_cnt), 64'(snap));
        check("rdy_low_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1 hold_rdy_low = 1'b0;
        @(negedge clk);
        check("rdy_raise_trigger_not_yet", 64'(rd.rd_trigger), 64'd0);
        @(negedge clk);
        check("rdy_raise_trigger_next", 64'(rd.rd_trigger), 64'd1);
        @(negedge clk);
        check("trigger_released_after_rdy_fall", 64'(rd.rd_trigger), 64'd0);
        wait_drain("drain_rdy_low");

        dsnap = done_cnt;
        push_byte(8'h3C, 1'b0);
        push_byte(8'h81, 1'b1);
        n = 0;
        while (!(mon_active && mon_n >= 17) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_data_bit3", 64'(n < 500), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midframe_reset_tx", 64'(tx), 64'd1);
        check("midframe_reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("after_reset_tx_high", 64'(tx), 64'd1);
        wait_drain("drain_after_reset");
        check("midframe_one_tx_done", 64'(done_cnt), 64'(dsnap + 1));

        snap = trig_cnt;
        @(posedge clk);
        #1 spur_req = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_idle_busy", 64'(busy), 64'd0);
        check("spurious_idle_no_trigger", 64'(trig_cnt), 64'(snap));

        dsnap = done_cnt;
        rsnap = reads;
        push_byte(8'hC3, 1'b1);
        n = 0;
        while (!(mon_active && mon_n >= 8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_spurious_point", 64'(n < 500), 64'd1);
        @(posedge clk);
        #1 spur_req = 1'b1;
        wait_drain("drain_spurious");
        check("spurious_frame_done", 64'(done_cnt), 64'(dsnap + 1));
        check("spurious_reads", 64'(reads), 64'(rsnap + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_buf_to_uart
